// File: rtl/quad_decoder_if.sv
// Encoder pins, control and status bundle for quad_decoder.
// The decoder connects through the slave modport; its driver uses master.
interface quad_decoder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             enable;
    logic             a_in;
    logic             b_in;
    logic             idx_in;
    logic             load;
    logic [WIDTH-1:0] data;
    logic             clr_err;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             step;
    logic             err;
    logic [WIDTH-1:0] cap;
    logic             cap_valid;

    modport master (
        output enable, a_in, b_in, idx_in, load, data, clr_err,
        input  count, dir, step, err, cap, cap_valid
    );

    modport slave (
        input  enable, a_in, b_in, idx_in, load, data, clr_err,
        output count, dir, step, err, cap, cap_valid
    );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes and filters A/B/index pins, decodes
// up/down steps into a position counter, flags illegal jumps, captures on index.
module quad_decoder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned FILTER = 2
) (
    input logic           clk,
    input logic           reset,
    quad_decoder_if.slave bus
);
    localparam int unsigned FCW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int unsigned ICW = $clog2(FILTER + 3);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    // Channel bit order in the pin vectors: [2] = A, [1] = B, [0] = index.
    logic [2:0]          sync1_q, sync1_d;
    logic [2:0]          sync2_q, sync2_d;
    logic [2:0]          filt_q, filt_d;
    logic [2:0][FCW-1:0] fcnt_q, fcnt_d;
    logic [1:0]          prev_ab_q, prev_ab_d;
    logic                prev_idx_q, prev_idx_d;
    state_e              state_q, state_d;
    logic [ICW-1:0]      init_cnt_q, init_cnt_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic                dir_q, dir_d;
    logic                step_q, step_d;
    logic                err_q, err_d;
    logic [WIDTH-1:0]    cap_q, cap_d;
    logic                cap_valid_q, cap_valid_d;

    logic [1:0] cur_ab;
    logic [1:0] moved;
    logic       illegal;
    logic       legal;
    logic       up;
    logic       idx_rise;
    logic       run;

    always_comb begin
        sync1_d = {bus.a_in, bus.b_in, bus.idx_in};
        sync2_d = sync1_q;
        filt_d  = filt_q;
        fcnt_d  = fcnt_q;
        // A filtered bit flips only after FILTER consecutive disagreeing samples.
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
                fcnt_d[i] = '0;
            end else if (fcnt_q[i] == FCW'(FILTER - 1)) begin
                filt_d[i] = sync2_q[i];
                fcnt_d[i] = '0;
            end else begin
                fcnt_d[i] = fcnt_q[i] + FCW'(1);
            end
        end

        cur_ab   = filt_q[2:1];
        moved    = cur_ab ^ prev_ab_q;
        illegal  = (moved == 2'b11);
        legal    = (moved != 2'b00) && !illegal;
        // A leads: the new A equals the old B inverted on every forward step.
        up       = cur_ab[1] ^ prev_ab_q[0];
        idx_rise = filt_q[0] & ~prev_idx_q;
        run      = (state_q == ST_RUN);

        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        prev_ab_d   = cur_ab;
        prev_idx_d  = filt_q[0];
        count_d     = count_q;
        dir_d       = dir_q;
        step_d      = 1'b0;
        err_d       = err_q;
        cap_d       = cap_q;
        cap_valid_d = 1'b0;

        if (state_q == ST_INIT) begin
            if (init_cnt_q == ICW'(FILTER + 2)) begin
                state_d = ST_RUN;
            end else begin
                init_cnt_d = init_cnt_q + ICW'(1);
            end
        end

        if (bus.load) begin
            count_d = bus.data;
        end else if (run && legal && bus.enable) begin
            count_d = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            dir_d   = up;
            step_d  = 1'b1;
        end

        if (bus.clr_err) begin
            err_d = 1'b0;
        end
        if (run && illegal) begin
            err_d = 1'b1;
        end

        if (run && idx_rise) begin
            cap_d       = count_q;
            cap_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            filt_q      <= '0;
            fcnt_q      <= '0;
            prev_ab_q   <= '0;
            prev_idx_q  <= 1'b0;
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            count_q     <= '0;
            dir_q       <= 1'b0;
            step_q      <= 1'b0;
            err_q       <= 1'b0;
            cap_q       <= '0;
            cap_valid_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            prev_ab_q   <= prev_ab_d;
            prev_idx_q  <= prev_idx_d;
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            count_q     <= count_d;
            dir_q       <= dir_d;
            step_q      <= step_d;
            err_q       <= err_d;
            cap_q       <= cap_d;
            cap_valid_q <= cap_valid_d;
        end
    end

    assign bus.count     = count_q;
    assign bus.dir       = dir_q;
    assign bus.step      = step_q;
    assign bus.err       = err_q;
    assign bus.cap       = cap_q;
    assign bus.cap_valid = cap_valid_q;
endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (WIDTH = 16, FILTER = 2) with hand-computed
// expected counts, directions, flags and captures.
module tb_quad_decoder;
    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    int   step_cnt = 0;
    int   capv_cnt = 0;
    int   base;
    logic [1:0] up_seq   [4];
    logic [1:0] down_seq [4];

    quad_decoder_if #(.WIDTH(16)) bus ();

    quad_decoder #(.WIDTH(16), .FILTER(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tallies sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.step)      step_cnt++;
        if (bus.cap_valid) capv_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ab(input logic [1:0] v);
        {bus.a_in, bus.b_in} = v;
        tick(6);
    endtask

    task automatic do_load(input logic [15:0] d);
        bus.load = 1'b1;
        bus.data = d;
        tick(1);
        bus.load = 1'b0;
    endtask

    initial begin
        up_seq   = '{2'b01, 2'b00, 2'b10, 2'b11};
        down_seq = '{2'b10, 2'b00, 2'b01, 2'b11};
        reset = 1'b1;
        bus.enable = 1'b1; bus.a_in = 1'b1; bus.b_in = 1'b1; bus.idx_in = 1'b0;
        bus.load = 1'b0; bus.data = '0; bus.clr_err = 1'b0;
        tick(2);
        check_eq("rst_count", 32'(bus.count), 32'h0);
        check_eq("rst_flags", {28'h0, bus.dir, bus.step, bus.err, bus.cap_valid}, 32'h0);
        check_eq("rst_cap", 32'(bus.cap), 32'h0);
        reset = 1'b0;

        // Filtered AB goes 00 -> 11 while still in INIT; must not decode.
        tick(5);
        check_eq("init_err", 32'(bus.err), 32'h0);
        check_eq("init_count", 32'(bus.count), 32'h0);
        tick(5);
        check_eq("idle_steps", 32'(step_cnt), 32'h0);
        check_eq("idle_err", 32'(bus.err), 32'h0);

        // First up edge with latency checks: step lands 4 edges after sampling.
        base = step_cnt;
        {bus.a_in, bus.b_in} = up_seq[0];
        tick(4);
        check_eq("lat_step_early", 32'(bus.step), 32'h0);
        check_eq("lat_count_early", 32'(bus.count), 32'h0);
        tick(1);
        check_eq("lat_step", 32'(bus.step), 32'h1);
        check_eq("lat_count", 32'(bus.count), 32'h1);
        tick(1);
        check_eq("step_one_cycle", 32'(bus.step), 32'h0);
        for (int e = 1; e < 16; e++) set_ab(up_seq[e % 4]);
        check_eq("up_count", 32'(bus.count), 32'd16);
        check_eq("up_dir", 32'(bus.dir), 32'h1);
        check_eq("up_steps", 32'(step_cnt - base), 32'd16);

        base = step_cnt;
        for (int e = 0; e < 16; e++) set_ab(down_seq[e % 4]);
        check_eq("down_count", 32'(bus.count), 32'h0);
        check_eq("down_dir", 32'(bus.dir), 32'h0);
        check_eq("down_steps", 32'(step_cnt - base), 32'd16);
        check_eq("no_err_seq", 32'(bus.err), 32'h0);

        // Wrap in both directions.
        do_load(16'hFFFF);
        check_eq("load_count", 32'(bus.count), 32'hFFFF);
        set_ab(2'b01);
        check_eq("wrap_up", 32'(bus.count), 32'h0);
        check_eq("wrap_up_dir", 32'(bus.dir), 32'h1);
        set_ab(2'b11);
        check_eq("wrap_down", 32'(bus.count), 32'hFFFF);
        check_eq("wrap_down_dir", 32'(bus.dir), 32'h0);

        // Load in the same cycle the up step 11->01 is decoded.
        base = step_cnt;
        {bus.a_in, bus.b_in} = 2'b01;
        tick(4);
        bus.load = 1'b1;
        bus.data = 16'h0500;
        tick(1);
        bus.load = 1'b0;
        check_eq("load_step_count", 32'(bus.count), 32'h0500);
        check_eq("load_step_pulse", 32'(bus.step), 32'h0);
        check_eq("load_step_dir", 32'(bus.dir), 32'h0);
        tick(1);
        check_eq("load_step_steps", 32'(step_cnt - base), 32'h0);

        // One-cycle glitch on A.
        base = step_cnt;
        bus.a_in = 1'b1;
        tick(1);
        bus.a_in = 1'b0;
        tick(8);
        check_eq("glitch_count", 32'(bus.count), 32'h0500);
        check_eq("glitch_steps", 32'(step_cnt - base), 32'h0);
        check_eq("glitch_err", 32'(bus.err), 32'h0);

        set_ab(2'b00);
        set_ab(2'b10);
        check_eq("pre_ill_count", 32'(bus.count), 32'h0502);
        set_ab(2'b01);
        check_eq("ill_err", 32'(bus.err), 32'h1);
        check_eq("ill_count", 32'(bus.count), 32'h0502);
        check_eq("ill_dir", 32'(bus.dir), 32'h1);

        // Second illegal jump decoded in the same cycle as clr_err: set wins.
        {bus.a_in, bus.b_in} = 2'b10;
        tick(4);
        bus.clr_err = 1'b1;
        tick(1);
        bus.clr_err = 1'b0;
        check_eq("ill_clr_same", 32'(bus.err), 32'h1);
        tick(1);
        bus.clr_err = 1'b1;
        tick(1);
        bus.clr_err = 1'b0;
        check_eq("clr_err", 32'(bus.err), 32'h0);
        check_eq("clr_count", 32'(bus.count), 32'h0502);

        // Index rising edge together with an up step 10->11.
        do_load(16'h0123);
        base = capv_cnt;
        {bus.a_in, bus.b_in} = 2'b11;
        bus.idx_in = 1'b1;
        tick(6);
        check_eq("cap_value", 32'(bus.cap), 32'h0123);
        check_eq("cap_count", 32'(bus.count), 32'h0124);
        check_eq("cap_pulses", 32'(capv_cnt - base), 32'h1);
        check_eq("cap_valid_low", 32'(bus.cap_valid), 32'h0);
        bus.idx_in = 1'b0;
        tick(6);
        check_eq("idx_fall_nocap", 32'(capv_cnt - base), 32'h1);

        // Steps while disabled are dropped.
        bus.enable = 1'b0;
        base = step_cnt;
        set_ab(2'b01);
        set_ab(2'b00);
        set_ab(2'b10);
        check_eq("dis_count", 32'(bus.count), 32'h0124);
        check_eq("dis_steps", 32'(step_cnt - base), 32'h0);
        check_eq("dis_err", 32'(bus.err), 32'h0);
        bus.enable = 1'b1;
        set_ab(2'b11);
        check_eq("en_count", 32'(bus.count), 32'h0125);
        check_eq("en_steps", 32'(step_cnt - base), 32'h1);

        // Reset in the middle of a filter run.
        {bus.a_in, bus.b_in} = 2'b01;
        tick(2);
        reset = 1'b1;
        tick(1);
        check_eq("midrst_count", 32'(bus.count), 32'h0);
        check_eq("midrst_cap", 32'(bus.cap), 32'h0);
        check_eq("midrst_flags", {28'h0, bus.dir, bus.step, bus.err, bus.cap_valid}, 32'h0);
        reset = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature decoder: receives the two-phase A/B signals of an incremental encoder plus an index pulse and turns them into up/down count steps on an internal WIDTH-bit position counter. It is the input-side counterpart of the team's up/down counter with load: that block counts when told to step and which direction, while this block works out step and direction from raw encoder phases. It provides synchronization, glitch filtering, illegal-transition detection and index capture. Inputs are asynchronous pins; outputs feed register-mapped status logic.

## Interface
- WIDTH, 16, position counter and capture width (≥2)
- FILTER, 2, consecutive identical synchronized samples required before a filtered input changes (≥1)

- clk  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = decoded steps update count; 0 = count frozen
- a_in  in  1  encoder phase A, asynchronous
- b_in  in  1  encoder phase B, asynchronous
- idx_in  in  1  encoder index, asynchronous
- load  in  1  load count from data
- data  in  WIDTH  load value
- clr_err  in  1  clears err
- count  out  WIDTH  position count
- dir  out  1  direction of the last accepted step (1 = up)
- step  out  1  one-cycle pulse per accepted step
- err  out  1  sticky illegal-transition flag
- cap  out  WIDTH  count captured on an index rising edge
- cap_valid  out  1  one-cycle pulse when cap updates

## Operation
- Each of a_in, b_in and idx_in goes through a 2-flop synchronizer, then its own filter. The filter counter resets when the synchronized value equals the filtered value. The filtered value takes the new value once the synchronized value has differed from it for FILTER consecutive cycles.
- prev_ab holds the filtered {A,B} from the previous cycle. A transition is a cycle where filtered {A,B} differs from prev_ab.
- Up sequence (A leads): 00→10→11→01→00. Down sequence is the reverse. When both bits change in one cycle the transition is illegal.
- FSM:
  - INIT is entered on reset and lasts FILTER+3 cycles. In INIT prev_ab tracks the filtered value and nothing is decoded. INIT then moves to RUN.
  - RUN decodes every cycle.
  - No other states exist.
- Decoded actions in RUN, priority highest first:
  1. load = 1: count ← data. Any step decoded that cycle is discarded (no step pulse, dir unchanged).
  2. Legal transition with enable = 1: count ± 1 modulo 2^WIDTH (wraps both ways); dir updates; step pulses.
  3. Legal transition with enable = 0: no count, dir or step change.
- An illegal transition sets err whatever the state of enable; count and dir are unchanged.
- err clears on clr_err. If an illegal transition and clr_err occur in the same cycle, set wins.
- A rising edge of filtered idx in RUN loads cap with the count value before that cycle's update, and cap_valid pulses. Index edges during INIT are ignored.
- load is honoured in INIT as well as RUN.

## Timing
- After reset all outputs read 0: count, dir, step, err, cap and cap_valid. The synchronizers, filters, filter counters and prev_ab also reset to 0. The FSM enters INIT.
- Input latency: if a new a_in value is first sampled at edge k, the filtered value changes at edge k+1+FILTER and count/step update at edge k+2+FILTER. With FILTER = 2, count changes at edge k+4.
- A pulse shorter than FILTER cycles at the synchronizer output is rejected completely.
- Maximum step rate: one step per FILTER+1 cycles at least; faster edges are filtered or flagged.
- load takes effect on the next edge (1-cycle latency).
- step and cap_valid are high for exactly one cycle.
- reset asserted at any time, mid-step or mid-filter, returns everything to reset values on the next edge.

## Test plan
- Reset, inputs held at 11 → stays in INIT for 5 cycles with no err, no step and count = 0; after that, no spurious activity.
- Four full up cycles (16 edges, phase held 6 clk each, FILTER = 2) → count = 16, dir = 1, 16 step pulses, each 4 cycles after its sampling edge. Reverse the sequence for 16 edges → count = 0, dir = 0.
- load with data = 0xFFFF, then one up step → count = 0x0000 (wrap). One down step → count = 0xFFFF. Apply load coincident with a step → count = data, no step pulse.
- 1-cycle glitch on a_in → no change to count, step or err. A at 10 jumping to 01 in one cycle → err = 1 and count unchanged. clr_err in the same cycle as a second illegal jump → err stays 1; clr_err alone → err = 0.
- count = 0x0123, then an idx_in rising edge coincident with an up step → cap = 0x0123, count = 0x0124, one cap_valid pulse.
- enable = 0 during 3 up steps → count frozen, no step. enable back to 1 and 1 more step → count advances by exactly 1.
